arb_requester: RTL and testbench

Client-side agent for the 4-way synchronous req/gnt arbiter; one instance sits in front of each bus master. It accepts a transfer command from the local master, raises `req`, waits for `gnt`, and counts granted beats. It drops `req` after the last beat, then waits until the arbiter's registered `gnt` has fallen before it accepts new work. A watchdog abandons requests that are never granted.

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_req_timer.sv | 37 +++
 rtl/arb_requester.sv | 158 +++++++++++++++
 tb/tb_arb_requester.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way req/gnt arbiter and its per-master requesters.
package arb_pkg;

  localparam int N_REQ     = 4;
  localparam int ARB_LEN_W = 8;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_REQ_WAIT = 5'b00010,
    ST_XFER     = 5'b00100,
    ST_RELEASE  = 5'b01000,
    ST_GAP      = 5'b10000
  } arb_state_e;

endpackage

// File: rtl/arb_req_timer.sv
// Loadable saturating counter (up or down) with a terminal-value flag.
module arb_req_timer #(
  parameter int           W    = 4,
  parameter bit           UP   = 1'b1,
  parameter logic [W-1:0] TERM = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (UP) begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/arb_requester.sv
// Client-side agent for the req/gnt arbiter: accepts a command, requests the bus,
// counts granted beats, and holds off new work until the arbiter's grant tail clears.
module arb_requester
  import arb_pkg::*;
#(
  parameter int LEN_W   = ARB_LEN_W,
  parameter int TIMEOUT = 64,
  parameter int GAP     = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat,
  output logic             beat_last,
  output logic [LEN_W-1:0] remaining,
  output logic             done,
  output logic             timeout,
  output logic             abort,
  output logic             busy
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam int GP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [WD_W-1:0] WD_TERM  = WD_W'(TIMEOUT - 1);
  localparam logic [GP_W-1:0] GP_LOAD  = GP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam arb_state_e      POST_REL = (GAP == 0) ? ST_IDLE : ST_GAP;

  arb_state_e       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             ab_q, ab_d;
  logic             wd_clr, wd_en, wd_term;
  logic             gap_ld, gap_en, gap_term;

  // Beats only count while actually requesting; a grant tail in RELEASE is not data.
  assign beat      = gnt & ((state_q == ST_REQ_WAIT) | (state_q == ST_XFER)) & (rem_q != '0);
  assign beat_last = beat & (rem_q == LEN_W'(1));
  assign cmd_ready = (state_q == ST_IDLE) & ~reset;
  assign busy      = (state_q != ST_IDLE);
  assign req       = req_q;
  assign remaining = rem_q;
  assign done      = done_q;
  assign timeout   = to_q;
  assign abort     = ab_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    req_d   = req_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    ab_d    = 1'b0;
    wd_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rem_d  = cmd_len;
          wd_clr = 1'b1;
          if (cmd_len != '0) begin
            req_d   = 1'b1;
            state_d = ST_REQ_WAIT;
          end else begin
            done_d  = 1'b1;
            state_d = POST_REL;
          end
        end
      end
      ST_REQ_WAIT: begin
        if (beat) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_XFER;
          end
        end else if (!gnt && wd_term) begin
          req_d   = 1'b0;
          to_d    = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_XFER: begin
        if (beat) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_RELEASE;
          end
        end else begin
          // Grant withdrawn mid-burst: keep the unfinished count for the master.
          req_d   = 1'b0;
          ab_d    = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!gnt) state_d = POST_REL;
      end
      ST_GAP: begin
        if (gap_term) state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wd_en  = (state_q == ST_REQ_WAIT) & ~gnt;
  assign gap_ld = (state_d == ST_GAP) & (state_q != ST_GAP);
  assign gap_en = (state_q == ST_GAP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      req_q   <= req_d;
      done_q  <= done_d;
      to_q    <= to_d;
      ab_q    <= ab_d;
    end
  end

  arb_req_timer #(.W(WD_W), .UP(1'b1), .TERM(WD_TERM)) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .load_i     (wd_clr),
    .load_val_i ('0),
    .en_i       (wd_en),
    .term_o     (wd_term)
  );

  arb_req_timer #(.W(GP_W), .UP(1'b0), .TERM('0)) u_gap (
    .clock      (clock),
    .reset      (reset),
    .load_i     (gap_ld),
    .load_val_i (GP_LOAD),
    .en_i       (gap_en),
    .term_o     (gap_term)
  );

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester against a one-cycle registered arbiter model,
// with a higher-priority hog and a gnt override for fault-like sequences.
module tb_arb_requester;

  localparam int LW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_ready, req, gnt, beat, beat_last, done, timeout, abort, busy;
  logic [LW-1:0] remaining;

  logic arb_q = 1'b0;
  logic hog = 1'b0;
  logic f_en = 1'b0;
  logic f_val = 1'b0;

  always #5 clock = ~clock;

  // Arbiter model: grant registered from req, lost to the hog.
  always @(posedge clock) arb_q <= reset ? 1'b0 : (req & ~hog);
  assign gnt = f_en ? f_val : arb_q;

  arb_requester #(.LEN_W(LW), .TIMEOUT(64), .GAP(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .req       (req),
    .gnt       (gnt),
    .beat      (beat),
    .beat_last (beat_last),
    .remaining (remaining),
    .done      (done),
    .timeout   (timeout),
    .abort     (abort),
    .busy      (busy)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", nm, $signed(act), $signed(exp));
    end
  endtask

  // Cycle t is relative to the cycle the command is presented (t=0); -1 = never.
  typedef struct {
    int len; int hog; int fs; int fe; int fv;
    int e_rise; int e_first; int e_last; int e_beats; int e_rem1;
    int e_done; int e_to; int e_ab; int e_fall; int e_remev; int e_ready;
  } vec_t;

  vec_t tbl [7];

  int rise, first, last, nb, rem1, dn, to, ab, fall, remev, rdy, nev, nd;

  initial begin
    //          len hog  fs  fe fv rise first last beats rem1 done  to  ab fall remev ready
    tbl[0] = '{  3,  0, -1, -1, 0,   1,   2,    4,   3,   3,   5, -1, -1,   5,  0,    8};
    tbl[1] = '{  1,  0, -1, -1, 0,   1,   2,    2,   1,   1,   3, -1, -1,   3,  0,    6};
    tbl[2] = '{  0,  0, -1, -1, 0,  -1,  -1,   -1,   0,   0,   1, -1, -1,  -1,  0,    2};
    tbl[3] = '{255,  0, -1, -1, 0,   1,   2,  256, 255, 255, 257, -1, -1, 257,  0,  260};
    tbl[4] = '{  4,100, -1, -1, 0,   1,  -1,   -1,   0,   4,  -1, 65, -1,  65,  4,   67};
    tbl[5] = '{  5,  0,  4, 20, 0,   1,   2,   -1,   2,   5,  -1, -1,  5,   5,  3,    7};
    tbl[6] = '{  2,  0,  4,  5, 1,   1,   2,    3,   2,   2,   4, -1, -1,   4,  0,    8};

    // Reset held: everything low, no command taken.
    repeat (3) begin
      @(posedge clock); #2;
      chk("rst_req", req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rem", remaining, 0);
      chk("rst_evt", {done, timeout, abort, beat}, 0);
      chk("rst_ready", cmd_ready, 0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rst_rel_ready", cmd_ready, 1);
    chk("rst_rel_busy", busy, 0);

    for (int r = 0; r < 7; r++) begin
      rise = -1; first = -1; last = -1; nb = 0; rem1 = -1; dn = -1;
      to = -1; ab = -1; fall = -1; remev = -1; rdy = -1; nev = 0;
      for (int t = 0; t < 400 && rdy < 0; t++) begin
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_len   = (t == 0) ? tbl[r].len[LW-1:0] : 8'd7;
        hog       = (t < tbl[r].hog);
        f_en      = (t >= tbl[r].fs) && (t <= tbl[r].fe);
        f_val     = tbl[r].fv[0];
        #1;
        if (t == 0) begin
          chk($sformatf("r%0d_ready0", r), cmd_ready, 1);
        end else begin
          if (req && rise < 0) rise = t;
          if (!req && rise >= 0 && fall < 0) fall = t;
          if (beat) begin nb++; if (first < 0) first = t; end
          if (beat_last) last = t;
          if (t == 1) rem1 = int'(remaining);
          if (done | timeout | abort) begin nev++; remev = int'(remaining); end
          if (done && dn < 0) dn = t;
          if (timeout && to < 0) to = t;
          if (abort && ab < 0) ab = t;
          if (cmd_ready) begin rdy = t; cmd_valid = 1'b0; end
        end
      end
      cmd_valid = 1'b0; hog = 1'b0; f_en = 1'b0;
      chk($sformatf("r%0d_req_rise", r), rise, tbl[r].e_rise);
      chk($sformatf("r%0d_first_beat", r), first, tbl[r].e_first);
      chk($sformatf("r%0d_beat_last", r), last, tbl[r].e_last);
      chk($sformatf("r%0d_beats", r), nb, tbl[r].e_beats);
      chk($sformatf("r%0d_rem_t1", r), rem1, tbl[r].e_rem1);
      chk($sformatf("r%0d_done", r), dn, tbl[r].e_done);
      chk($sformatf("r%0d_timeout", r), to, tbl[r].e_to);
      chk($sformatf("r%0d_abort", r), ab, tbl[r].e_ab);
      chk($sformatf("r%0d_req_fall", r), fall, tbl[r].e_fall);
      chk($sformatf("r%0d_rem_evt", r), remev, tbl[r].e_remev);
      chk($sformatf("r%0d_events", r), nev, 1);
      chk($sformatf("r%0d_ready", r), rdy, tbl[r].e_ready);
    end

    // Reset in the middle of a 10-beat burst.
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_len = 8'd10;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #2;
    chk("mid_beat", beat, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    nd = 0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clock); #2;
      if (done | abort | timeout) nd++;
      chk("mid_rst_req", req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rem", remaining, 0);
      chk("mid_rst_ready", cmd_ready, 0);
    end
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", cmd_ready, 1);
    for (int t = 0; t < 3; t++) begin
      @(posedge clock); #2;
      if (done | abort | timeout) nd++;
    end
    chk("mid_no_evt", nd, 0);
    chk("mid_ready_after", cmd_ready, 1);
    chk("mid_req_after", req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
